receiver2b: RTL and testbench

Serial receiver paired with the two-byte transmitter on the same link. It oversamples the asynchronous serial line, recovers two consecutive 8N1 frames, and reassembles them into one 16-bit word. It presents the word with a one-cycle valid pulse to the downstream logic. It sits directly across the wire from the transmitter, which sends the low byte first, LSB first, with one stop bit between frames.

---
 rtl/receiver2b.sv | 193 +++++++++++++++++++
 tb/tb_receiver2b.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/receiver2b.sv
// Two-frame 8N1 serial receiver: reassembles low byte then high byte into a 16-bit word.
// Optional inter-frame timeout is enabled by defining RX2B_TIMEOUT_EN.
module receiver2b #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        framing_error,
  output logic        timeout_error,
  output logic [1:0]  state_out
);

  localparam int unsigned TickW = $clog2(CLKS_PER_BIT);
  localparam logic [TickW-1:0] TickMid = TickW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TickW-1:0] TickEnd = TickW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0 || TIMEOUT_BITS == 0) begin : g_param_check
    $error("receiver2b: CLKS_PER_BIT must be even and >= 4, TIMEOUT_BITS nonzero");
  end

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } state_e;

  logic             r_rx_meta, r_rx_s, r_rx_s_d;
  state_e           r_state, w_state_d;
  logic [TickW-1:0] r_tick, w_tick_d;
  logic [2:0]       r_bit_cnt, w_bit_cnt_d;
  logic [7:0]       r_shift, w_shift_d;
  logic [7:0]       r_low_byte, w_low_byte_d;
  logic             r_byte_idx, w_byte_idx_d;
  logic [15:0]      r_data_out, w_data_out_d;
  logic             r_data_valid, w_data_valid_d;
  logic             r_framing_error, w_framing_error_d;
  logic             w_fall;

`ifdef RX2B_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_BITS * CLKS_PER_BIT);
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
  logic [ToW-1:0] r_to_cnt, w_to_cnt_d;
  logic           r_timeout_error, w_timeout_error_d;
`endif

  // Synchronizer idles high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_s_d  <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_rx_s_d  <= r_rx_s;
    end
  end

  assign w_fall = r_rx_s_d & ~r_rx_s;

  always_comb begin
    w_state_d         = r_state;
    w_tick_d          = r_tick;
    w_bit_cnt_d       = r_bit_cnt;
    w_shift_d         = r_shift;
    w_low_byte_d      = r_low_byte;
    w_byte_idx_d      = r_byte_idx;
    w_data_out_d      = r_data_out;
    w_data_valid_d    = 1'b0;
    w_framing_error_d = 1'b0;
`ifdef RX2B_TIMEOUT_EN
    w_to_cnt_d        = r_to_cnt;
    w_timeout_error_d = 1'b0;
`endif
    unique case (r_state)
      StIdle: begin
        if (w_fall) begin
          w_tick_d  = '0;
          w_state_d = StStart;
`ifdef RX2B_TIMEOUT_EN
          w_to_cnt_d = '0;
`endif
        end
`ifdef RX2B_TIMEOUT_EN
        if (!w_fall && r_byte_idx) begin
          if (r_to_cnt == ToLast) begin
            w_to_cnt_d        = '0;
            w_byte_idx_d      = 1'b0;
            w_low_byte_d      = '0;
            w_timeout_error_d = 1'b1;
          end else begin
            w_to_cnt_d = r_to_cnt + ToW'(1);
          end
        end
`endif
      end
      StStart: begin
        if (r_tick == TickMid) begin
          w_tick_d = '0;
          if (!r_rx_s) begin
            w_bit_cnt_d = '0;
            w_state_d   = StData;
          end else begin
            w_state_d = StIdle;
          end
        end else begin
          w_tick_d = r_tick + TickW'(1);
        end
      end
      StData: begin
        if (r_tick == TickEnd) begin
          w_tick_d  = '0;
          w_shift_d = {r_rx_s, r_shift[7:1]};
          if (r_bit_cnt == 3'd7) begin
            w_state_d = StStop;
          end else begin
            w_bit_cnt_d = r_bit_cnt + 3'd1;
          end
        end else begin
          w_tick_d = r_tick + TickW'(1);
        end
      end
      StStop: begin
        if (r_tick == TickEnd) begin
          w_tick_d  = '0;
          w_state_d = StIdle;
          if (!r_rx_s) begin
            w_framing_error_d = 1'b1;
            w_byte_idx_d      = 1'b0;
            w_low_byte_d      = '0;
          end else if (!r_byte_idx) begin
            w_low_byte_d = r_shift;
            w_byte_idx_d = 1'b1;
          end else begin
            w_data_out_d   = {r_shift, r_low_byte};
            w_data_valid_d = 1'b1;
            w_byte_idx_d   = 1'b0;
          end
        end else begin
          w_tick_d = r_tick + TickW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= StIdle;
      r_tick          <= '0;
      r_bit_cnt       <= '0;
      r_shift         <= '0;
      r_low_byte      <= '0;
      r_byte_idx      <= 1'b0;
      r_data_out      <= '0;
      r_data_valid    <= 1'b0;
      r_framing_error <= 1'b0;
`ifdef RX2B_TIMEOUT_EN
      r_to_cnt        <= '0;
      r_timeout_error <= 1'b0;
`endif
    end else begin
      r_state         <= w_state_d;
      r_tick          <= w_tick_d;
      r_bit_cnt       <= w_bit_cnt_d;
      r_shift         <= w_shift_d;
      r_low_byte      <= w_low_byte_d;
      r_byte_idx      <= w_byte_idx_d;
      r_data_out      <= w_data_out_d;
      r_data_valid    <= w_data_valid_d;
      r_framing_error <= w_framing_error_d;
`ifdef RX2B_TIMEOUT_EN
      r_to_cnt        <= w_to_cnt_d;
      r_timeout_error <= w_timeout_error_d;
`endif
    end
  end

  assign data_out      = r_data_out;
  assign data_valid    = r_data_valid;
  assign framing_error = r_framing_error;
  assign state_out     = r_state;
`ifdef RX2B_TIMEOUT_EN
  assign timeout_error = r_timeout_error;
`else
  assign timeout_error = 1'b0;
`endif

endmodule

// File: tb/tb_receiver2b.sv
// Scoreboard bench for receiver2b: a byte-pairing model queues expected events, a monitor checks them.
// Timeout scenario follows RX2B_TIMEOUT_EN.
module tb_receiver2b;

  localparam int CPB   = 16;
  localparam int TOBIT = 20;

  logic        clk;
  logic        rst_n;
  logic        rx;
  logic [15:0] data_out;
  logic        data_valid;
  logic        framing_error;
  logic        timeout_error;
  logic [1:0]  state_out;

  receiver2b #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_BITS(TOBIT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .framing_error(framing_error),
    .timeout_error(timeout_error),
    .state_out    (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = word, 1 = framing error, 2 = timeout; lo/hi bound the timeout cycle
  typedef struct {
    int          kind;
    logic [15:0] data;
    int          lo;
    int          hi;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: frames pair up as (low, high); a bad frame voids any pending byte.
  logic [7:0] pend_byte;
  bit         pend_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_frame(input logic [7:0] b, input bit good);
    if (!good) begin
      q.push_back('{kind: 1, data: 16'h0, lo: 0, hi: 0});
      pend_valid = 1'b0;
    end else if (pend_valid) begin
      q.push_back('{kind: 0, data: {b, pend_byte}, lo: 0, hi: 0});
      pend_valid = 1'b0;
    end else begin
      pend_byte  = b;
      pend_valid = 1'b1;
    end
  endfunction

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good);
    model_frame(b, good);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(good);
    rx = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * CPB) @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expectation per flagged cycle.
  int   mon_n;
  int   mon_kind;
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      mon_n = int'(data_valid) + int'(framing_error) + int'(timeout_error);
      if (mon_n > 1) check("flags_exclusive", mon_n, 1);
      if (mon_n != 0) begin
        mon_kind = data_valid ? 0 : (framing_error ? 1 : 2);
        if (q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_event: got kind %0d (data 0x%0h), expected none",
                   mon_kind, data_out);
        end else begin
          mon_e = q.pop_front();
          check("event_kind", mon_kind, mon_e.kind);
          if (mon_kind == 0 && mon_e.kind == 0) check("data_out", data_out, mon_e.data);
          if (mon_kind == 2 && mon_e.kind == 2) begin
            n_checks++;
            if (cyc < mon_e.lo || cyc > mon_e.hi) begin
              n_errors++;
              $display("FAIL timeout_time: got cycle %0d, expected %0d..%0d",
                       cyc, mon_e.lo, mon_e.hi);
            end
          end
        end
      end
    end
  end

  bit saw_start;
  bit saw_other;
  int c0;

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_data_out", data_out, 16'h0000);
    check("rst_data_valid", data_valid, 1'b0);
    check("rst_framing_error", framing_error, 1'b0);
    check("rst_timeout_error", timeout_error, 1'b0);
    check("rst_state_out", state_out, 2'd0);
    rst_n = 1'b1;
    idle_bits(2);

    // Basic back-to-back word
    send_byte(8'h5A, 1'b1);
    send_byte(8'hA5, 1'b1);
    idle_bits(2);
    check("word_a55a_held", data_out, 16'hA55A);

    // Short low glitch from idle
    check("glitch_pre_idle", state_out, 2'd0);
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    saw_start = 1'b0;
    saw_other = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (state_out == 2'd1) saw_start = 1'b1;
      if (state_out == 2'd2 || state_out == 2'd3) saw_other = 1'b1;
    end
    check("glitch_start_seen", saw_start, 1'b1);
    check("glitch_no_data_state", saw_other, 1'b0);
    check("glitch_back_idle", state_out, 2'd0);
    check("glitch_data_out", data_out, 16'hA55A);

    // Framing error, then a good word must still pair correctly
    send_byte(8'h12, 1'b0);
    idle_bits(2);
    check("fe_data_out_kept", data_out, 16'hA55A);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    idle_bits(1);

    // Lone byte followed by a long idle
`ifdef RX2B_TIMEOUT_EN
    send_byte(8'h34, 1'b1);
    c0 = cyc;
    q.push_back('{kind: 2, data: 16'h0, lo: c0 + TOBIT * CPB - 20, hi: c0 + TOBIT * CPB + 10});
    pend_valid = 1'b0;
    rx = 1'b1;
    repeat (400) @(posedge clk);
    #1;
    send_byte(8'hEF, 1'b1);
    send_byte(8'hBE, 1'b1);
`else
    send_byte(8'h34, 1'b1);
    rx = 1'b1;
    repeat (400) @(posedge clk);
    #1;
    send_byte(8'h12, 1'b1);
`endif
    idle_bits(1);

    // Three words back-to-back
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h80, 1'b1);
    idle_bits(2);
    check("three_words_last", data_out, 16'h8001);

    // Reset in the 4th data bit of frame 2 of word 0xFFFF
    check("queue_before_reset", q.size(), 0);
    send_byte(8'hFF, 1'b1);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    rx = 1'b1;
    repeat (CPB / 2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    pend_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_data_out", data_out, 16'h0000);
    check("midrst_state_out", state_out, 2'd0);
    check("midrst_flags", {data_valid, framing_error, timeout_error}, 3'b000);
    rst_n = 1'b1;
    idle_bits(2);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    idle_bits(2);
    check("post_rst_word", data_out, 16'h0001);

    // Randomized frames with occasional bad stop bits
    for (int i = 0; i < 60; i++) begin
      logic [7:0] b;
      bit         good;
      b    = 8'($urandom);
      good = ($urandom_range(0, 7) != 0);
      send_byte(b, good);
      idle_bits(good ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2)));
    end

    idle_bits(3);
    check("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
